// File: rtl/tri_gate_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tri_gate_pkg
// Description : Shared definitions for the trilib N-input pipelined gate.
//               Mode select width, mode encodings and a legality check
//               for the mode field.
// Revision    : 1.0 - initial release
// ============================================================================
package tri_gate_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] GATE_AND  = 3'd0;
    localparam logic [MODE_W-1:0] GATE_NAND = 3'd1;
    localparam logic [MODE_W-1:0] GATE_OR   = 3'd2;
    localparam logic [MODE_W-1:0] GATE_NOR  = 3'd3;
    localparam logic [MODE_W-1:0] GATE_XOR  = 3'd4;
    localparam logic [MODE_W-1:0] GATE_XNOR = 3'd5;

    // Encodings above GATE_XNOR (6 and 7) have no defined function.
    function automatic logic mode_is_legal(input logic [MODE_W-1:0] m);
        return (m <= GATE_XNOR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tri_gate_reduce.sv
`default_nettype none
// ============================================================================
// Module      : tri_gate_reduce
// Description : Combinational WIDTH x NUM_IN bitwise reduction with mode
//               decode. Bit i of the result reduces bit i of every operand.
//               Illegal modes produce an all-zero result.
// Ports       : mode  - function select (AND/NAND/OR/NOR/XOR/XNOR)
//               a     - packed operands, operand k at [k*WIDTH +: WIDTH]
//               y     - reduced result
//               par   - even parity of y (TRI_GATE_PIPE_PARITY_EN only)
// Config      : TRI_GATE_PIPE_PARITY_EN adds the par output.
// Revision    : 1.0 - initial release
// ============================================================================
module tri_gate_reduce
    import tri_gate_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int NUM_IN = 2
) (
    input  logic [MODE_W-1:0]       mode,
    input  logic [0:NUM_IN*WIDTH-1] a,
`ifdef TRI_GATE_PIPE_PARITY_EN
    output logic                    par,
`endif
    output logic [0:WIDTH-1]        y
);

    logic [0:WIDTH-1] w_and;
    logic [0:WIDTH-1] w_or;
    logic [0:WIDTH-1] w_xor;

    always_comb begin
        w_and = '1;
        w_or  = '0;
        w_xor = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            w_and = w_and & a[k*WIDTH +: WIDTH];
            w_or  = w_or  | a[k*WIDTH +: WIDTH];
            w_xor = w_xor ^ a[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        y = '0;
        case (mode)
            GATE_AND:  y =  w_and;
            GATE_NAND: y = ~w_and;
            GATE_OR:   y =  w_or;
            GATE_NOR:  y = ~w_or;
            GATE_XOR:  y =  w_xor;
            GATE_XNOR: y = ~w_xor;
            default:   y = '0;
        endcase
    end

`ifdef TRI_GATE_PIPE_PARITY_EN
    // Even parity: par makes the total count of ones in {y, par} even.
    assign par = ^y;
`endif

endmodule
`default_nettype wire

// File: rtl/tri_gate_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tri_gate_pipe
// Description : Parametrised, pipelined N-input bitwise gate. Operands are
//               reduced combinationally, then carried through STAGES
//               registered stages with valid tracking, activity hold (act)
//               and flush. A sticky flag records any accepted illegal mode.
// Ports       : nclk     - clock, rising edge
//               rst      - asynchronous active-high reset
//               act      - advance enable, 0 holds every stage
//               flush    - clears all in-flight valids (priority over act)
//               in_vld   - operand set valid
//               mode     - function select, sampled with operands
//               a        - NUM_IN packed operands of WIDTH bits
//               y/y_vld  - last-stage result and valid
//               y_par    - even parity of y (TRI_GATE_PIPE_PARITY_EN only)
//               mode_err - sticky illegal-mode flag, cleared by rst only
// Config      : TRI_GATE_PIPE_PARITY_EN adds parity registers and y_par.
// Revision    : 1.0 - initial release
// ============================================================================
module tri_gate_pipe
    import tri_gate_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int NUM_IN = 2,
    parameter int STAGES = 1
) (
    input  logic                    nclk,
    input  logic                    rst,
    input  logic                    act,
    input  logic                    flush,
    input  logic                    in_vld,
    input  logic [MODE_W-1:0]       mode,
    input  logic [0:NUM_IN*WIDTH-1] a,
    output logic [0:WIDTH-1]        y,
    output logic                    y_vld,
`ifdef TRI_GATE_PIPE_PARITY_EN
    output logic                    y_par,
`endif
    output logic                    mode_err
);

    logic [0:WIDTH-1]  w_red_y;
    logic [0:WIDTH-1]  data_q [STAGES];
    logic [0:WIDTH-1]  data_d [STAGES];
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    logic              mode_err_q;
    logic              mode_err_d;

`ifdef TRI_GATE_PIPE_PARITY_EN
    logic              w_red_par;
    logic [STAGES-1:0] par_q;
    logic [STAGES-1:0] par_d;
`endif

    tri_gate_reduce #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) u_reduce (
        .mode (mode),
        .a    (a),
`ifdef TRI_GATE_PIPE_PARITY_EN
        .par  (w_red_par),
`endif
        .y    (w_red_y)
    );

    // Data loads on every active cycle regardless of in_vld; only the valid
    // bits qualify it. Flush touches valids only, so data keeps its value.
    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (flush) begin
            vld_d = '0;
        end else if (act) begin
            data_d[0] = w_red_y;
            vld_d[0]  = in_vld;
            for (int s = 1; s < STAGES; s++) begin
                data_d[s] = data_q[s-1];
                vld_d[s]  = vld_q[s-1];
            end
        end
    end

`ifdef TRI_GATE_PIPE_PARITY_EN
    always_comb begin
        par_d = par_q;
        if (!flush && act) begin
            par_d[0] = w_red_par;
            for (int s = 1; s < STAGES; s++) begin
                par_d[s] = par_q[s-1];
            end
        end
    end
`endif

    // Only an operand set that is actually accepted can raise the flag.
    assign mode_err_d = mode_err_q |
                        (act & ~flush & in_vld & ~mode_is_legal(mode));

    always_ff @(posedge nclk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                data_q[s] <= '0;
            end
            vld_q      <= '0;
            mode_err_q <= 1'b0;
        end else begin
            data_q     <= data_d;
            vld_q      <= vld_d;
            mode_err_q <= mode_err_d;
        end
    end

`ifdef TRI_GATE_PIPE_PARITY_EN
    always_ff @(posedge nclk or posedge rst) begin
        if (rst) begin
            par_q <= '0;
        end else begin
            par_q <= par_d;
        end
    end

    assign y_par = par_q[STAGES-1];
`endif

    assign y        = data_q[STAGES-1];
    assign y_vld    = vld_q[STAGES-1];
    assign mode_err = mode_err_q;

endmodule
`default_nettype wire

// File: tb/tb_tri_gate_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_tri_gate_pipe
// Description : Self-checking bench for tri_gate_pipe. Two instances
//               (STAGES=2 and STAGES=3, WIDTH=4, NUM_IN=3) share stimulus.
//               A queue-based model of accepted operand sets predicts the
//               outputs of both on every cycle; directed literal checks pin
//               the model, followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tri_gate_pipe;

    localparam int W = 4;
    localparam int N = 3;

    logic          nclk = 1'b0;
    logic          rst;
    logic          act;
    logic          flush;
    logic          in_vld;
    logic [2:0]    mode;
    logic [0:N*W-1] a;

    logic [0:W-1]  y2, y3;
    logic          v2, v3, e2, e3;
`ifdef TRI_GATE_PIPE_PARITY_EN
    logic          p2, p3;
`endif

    always #5 nclk = ~nclk;

    tri_gate_pipe #(.WIDTH(W), .NUM_IN(N), .STAGES(2)) u_s2 (
        .nclk     (nclk),
        .rst      (rst),
        .act      (act),
        .flush    (flush),
        .in_vld   (in_vld),
        .mode     (mode),
        .a        (a),
        .y        (y2),
        .y_vld    (v2),
`ifdef TRI_GATE_PIPE_PARITY_EN
        .y_par    (p2),
`endif
        .mode_err (e2)
    );

    tri_gate_pipe #(.WIDTH(W), .NUM_IN(N), .STAGES(3)) u_s3 (
        .nclk     (nclk),
        .rst      (rst),
        .act      (act),
        .flush    (flush),
        .in_vld   (in_vld),
        .mode     (mode),
        .a        (a),
        .y        (y3),
        .y_vld    (v3),
`ifdef TRI_GATE_PIPE_PARITY_EN
        .y_par    (p3),
`endif
        .mode_err (e3)
    );

    int checks   = 0;
    int failures = 0;
    bit run_cmp  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       v;
        logic [3:0] d;
    } ent_t;

    // Each queue holds the last S accepted operand sets (oldest first);
    // the oldest one is what the pipeline output must show.
    ent_t h2[$];
    ent_t h3[$];
    logic merr;

    function automatic logic [3:0] gate(input logic [2:0] m, input logic [0:N*W-1] av);
        logic [3:0] o0, o1, o2;
        o0 = av[0:3];
        o1 = av[4:7];
        o2 = av[8:11];
        case (m)
            3'd0:    return o0 & o1 & o2;
            3'd1:    return ~(o0 & o1 & o2);
            3'd2:    return o0 | o1 | o2;
            3'd3:    return ~(o0 | o1 | o2);
            3'd4:    return o0 ^ o1 ^ o2;
            3'd5:    return ~(o0 ^ o1 ^ o2);
            default: return 4'h0;
        endcase
    endfunction

    always @(posedge nclk or posedge rst) begin
        if (rst) begin
            h2.delete();
            h3.delete();
            repeat (2) h2.push_back('0);
            repeat (3) h3.push_back('0);
            merr = 1'b0;
        end else begin
            if (flush) begin
                foreach (h2[i]) h2[i].v = 1'b0;
                foreach (h3[i]) h3[i].v = 1'b0;
            end else if (act) begin
                h2.push_back({in_vld, gate(mode, a)});
                h3.push_back({in_vld, gate(mode, a)});
                void'(h2.pop_front());
                void'(h3.pop_front());
            end
            if (act && !flush && in_vld && mode >= 3'd6) merr = 1'b1;
        end
    end

    // Cycle-by-cycle comparison, away from the active edge.
    always @(negedge nclk) begin
        if (run_cmp && h2.size() == 2 && h3.size() == 3) begin
            chk("s2_y",     32'(y2), 32'(h2[0].d));
            chk("s2_vld",   32'(v2), 32'(h2[0].v));
            chk("s2_err",   32'(e2), 32'(merr));
            chk("s3_y",     32'(y3), 32'(h3[0].d));
            chk("s3_vld",   32'(v3), 32'(h3[0].v));
            chk("s3_err",   32'(e3), 32'(merr));
`ifdef TRI_GATE_PIPE_PARITY_EN
            chk("s2_par",   32'(p2), 32'(^h2[0].d));
            chk("s3_par",   32'(p3), 32'(^h3[0].d));
`endif
        end
    end

    task automatic tick();
        @(posedge nclk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst    = 1'b1;
        act    = 1'b0;
        flush  = 1'b0;
        in_vld = 1'b0;
        mode   = 3'd0;
        a      = '0;
        repeat (2) @(posedge nclk);
        #1;
        rst     = 1'b0;
        run_cmp = 1'b1;

        // Reset state
        chk("rst_y",   32'(y2), 32'h0);
        chk("rst_vld", 32'(v2), 32'h0);
        chk("rst_err", 32'(e2), 32'h0);

        // NAND of F,F,3 -> C after exactly 2 edges
        act    = 1'b1;
        in_vld = 1'b1;
        mode   = 3'd1;
        a      = {4'hF, 4'hF, 4'h3};
        tick();
        in_vld = 1'b0;
        chk("nand_lat1_vld", 32'(v2), 32'h0);
        tick();
        chk("nand_y",   32'(y2), 32'hC);
        chk("nand_vld", 32'(v2), 32'h1);
`ifdef TRI_GATE_PIPE_PARITY_EN
        chk("nand_par", 32'(p2), 32'h0);
`endif

        // Back-to-back XOR / XNOR of 1,2,4
        in_vld = 1'b1;
        mode   = 3'd4;
        a      = {4'h1, 4'h2, 4'h4};
        tick();
        mode = 3'd5;
        tick();
        in_vld = 1'b0;
        chk("xor_y",   32'(y2), 32'h7);
        chk("xor_vld", 32'(v2), 32'h1);
        tick();
        chk("xnor_y",   32'(y2), 32'h8);
        chk("xnor_vld", 32'(v2), 32'h1);
        tick();
        chk("b2b_end_vld", 32'(v2), 32'h0);

        // act held low for 3 cycles stretches latency by 3
        in_vld = 1'b1;
        mode   = 3'd0;
        a      = {4'hF, 4'hF, 4'hF};
        tick();
        in_vld = 1'b0;
        act    = 1'b0;
        repeat (3) begin
            tick();
            chk("stall_vld", 32'(v2), 32'h0);
        end
        act = 1'b1;
        tick();
        chk("stall_out_vld", 32'(v2), 32'h1);
        chk("stall_out_y",   32'(y2), 32'hF);
        tick();
        chk("stall_once_vld", 32'(v2), 32'h0);

        // Flush one cycle after in_vld kills it in the 3-stage pipe
        in_vld = 1'b1;
        mode   = 3'd2;
        a      = {4'h1, 4'h0, 4'h8};
        tick();
        in_vld = 1'b0;
        flush  = 1'b1;
        tick();
        flush = 1'b0;
        repeat (4) begin
            tick();
            chk("flush_s3_vld", 32'(v3), 32'h0);
        end

        // in_vld together with flush is dropped
        in_vld = 1'b1;
        flush  = 1'b1;
        tick();
        in_vld = 1'b0;
        flush  = 1'b0;
        repeat (4) begin
            tick();
            chk("flush_same_s2_vld", 32'(v2), 32'h0);
            chk("flush_same_s3_vld", 32'(v3), 32'h0);
        end

        // Illegal mode: zero result, sticky error
        in_vld = 1'b1;
        mode   = 3'd7;
        a      = {4'hF, 4'hF, 4'hF};
        tick();
        in_vld = 1'b0;
        chk("ill_err", 32'(e2), 32'h1);
        tick();
        chk("ill_y",   32'(y2), 32'h0);
        chk("ill_vld", 32'(v2), 32'h1);
        in_vld = 1'b1;
        mode   = 3'd0;
        repeat (3) tick();
        in_vld = 1'b0;
        chk("ill_sticky", 32'(e2), 32'h1);

        // Asynchronous reset with valids in flight
        in_vld = 1'b1;
        mode   = 3'd3;
        a      = '0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("arst_y",   32'(y2), 32'h0);
        chk("arst_vld", 32'(v2), 32'h0);
        chk("arst_err", 32'(e2), 32'h0);
        chk("arst_s3_vld", 32'(v3), 32'h0);
`ifdef TRI_GATE_PIPE_PARITY_EN
        chk("arst_par", 32'(p2), 32'h0);
`endif
        in_vld = 1'b0;
        @(posedge nclk);
        #1;
        rst = 1'b0;
        repeat (4) begin
            tick();
            chk("post_rst_s2_vld", 32'(v2), 32'h0);
            chk("post_rst_s3_vld", 32'(v3), 32'h0);
        end

        // Randomized traffic against the model
        repeat (3000) begin
            act    = ($urandom_range(0, 3) != 0);
            flush  = ($urandom_range(0, 9) == 0);
            in_vld = 1'($urandom_range(0, 1));
            mode   = ($urandom_range(0, 19) == 0) ? 3'(6 + $urandom_range(0, 1))
                                                  : 3'($urandom_range(0, 5));
            a      = 12'($urandom);
            rst    = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst    = 1'b0;
        act    = 1'b0;
        in_vld = 1'b0;
        flush  = 1'b0;
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tri_gate_pipe.md
# tri_gate_pipe

Parametrised, pipelined N-input bitwise logic gate for the trilib library. It generalises the fixed two-input gate primitives to NUM_IN operands, a runtime-selected function (AND/NAND/OR/NOR/XOR/XNOR), and a STAGES-deep registered pipeline with valid tracking, activity hold and flush. It is used wherever wide reduction-style gating must be retimed across cycles in the core datapath.

## Interface
Parameters:
- WIDTH, 1, bits per operand and result.
- NUM_IN, 2, operand count; legal range 2..8.
- STAGES, 1, pipeline depth in cycles; legal range 1..4.

Ports (all vectors big-endian [0:n-1]):
- nclk  input  1  clock; all state on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- act  input  1  pipeline advance enable; 0 freezes every stage.
- flush  input  1  synchronous kill of all in-flight valids.
- in_vld  input  1  operand set valid.
- mode  input  3  function select, sampled with operands.
- a  input  NUM_IN*WIDTH  operands; operand k at bits k*WIDTH .. k*WIDTH+WIDTH-1.
- y  output  WIDTH  result from last stage.
- y_vld  output  1  result valid.
- y_par  output  1  even parity of y (only with TRI_GATE_PIPE_PARITY_EN).
- mode_err  output  1  sticky illegal-mode flag.

## Operation
- Mode encoding: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR; 6,7 illegal.
- Per bit i: reduce a[k*WIDTH+i] over k=0..NUM_IN-1 with the selected function; inverted modes invert the reduction. Illegal mode yields all-zeros result.
- Stage 1 registers the reduced result and in_vld; stages 2..STAGES copy the previous stage. y/y_vld come from stage STAGES.
- act=0: all data and valid registers hold; inputs ignored.
- flush=1: all valid bits cleared next edge regardless of act; data registers unchanged; in_vld on the same cycle is dropped. Flush has priority over act and in_vld.
- mode_err: set on the edge where act=1, flush=0, in_vld=1 and mode is 6 or 7; cleared only by rst.
- Data registers load on act even when in_vld=0 (valid qualifies; y content with y_vld=0 is don't-care but deterministic).

## Timing
- Latency: STAGES cycles from in_vld sampled (act=1) to y_vld=1; throughput one set per active cycle.
- Reset (asynchronous assert, synchronous-edge release): y=0, y_vld=0, y_par=0, mode_err=0; all stage registers zero.
- Reset mid-operation drops all in-flight results; first valid output after release follows full latency.
- act low for n cycles stretches latency by exactly n cycles; no results lost or duplicated.

## Configuration
- TRI_GATE_PIPE_PARITY_EN defined: even parity of the reduced result computed in stage 1, carried alongside data through all stages, driven on y_par; follows act hold, reset to 0.
- Undefined: no parity registers; y_par port absent.

## Structure
- Package tri_gate_pkg: mode localparams (GATE_AND..GATE_XNOR), mode width constant, legal-mode check function.
- Sub-module tri_gate_reduce: combinational WIDTH x NUM_IN reduction plus mode decode; tri_gate_pipe instantiates it once and owns the pipeline registers and mode_err.

## Test plan
- WIDTH=4, NUM_IN=3, STAGES=2, mode 1, a = 0xF,0xF,0x3 with in_vld -> y=0xC, y_vld=1 exactly 2 cycles later, y_par=0.
- Mode 4, a = 0x1,0x2,0x4 -> y=0x7; mode 5 same operands -> y=0x8; back-to-back inputs produce back-to-back outputs.
- In_vld at cycle 0, act=0 cycles 1-3 -> y_vld asserts cycle 5 (STAGES=2), y value unchanged.
- Flush one cycle after in_vld with STAGES=3 -> no y_vld ever; in_vld with flush same cycle -> dropped.
- Mode 7 with in_vld -> y=0 at latency, mode_err=1 and stays 1 through later legal traffic until rst.
- Assert rst mid-stream with valids in flight -> y, y_vld, y_par, mode_err go 0 immediately (asynchronous); no stale result after release.
